ka_split_sequencer_72bit: RTL and testbench

- Operand-side front end of the 72-bit GF(2) Karatsuba stage; it is the counterpart of the three-term overlap combiner.
- Accepts two 72-bit binary-polynomial operands and splits each into 36-bit halves.
- Issues the three Karatsuba sub-products (lo, hi, mid) sequentially to one shared 36x36 sub-multiplier over a valid/ready handshake.
- Collects the 71-bit results and presents p_lo, p_mid and p_hi, buffered, to the overlap combiner.

---
 rtl/ka_split_sequencer_72bit.sv | 162 ++++++++++++++++
 tb/tb_ka_split_sequencer_72bit.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ka_split_sequencer_72bit.sv
// ka_split_sequencer_72bit
// Operand-side front end of the 72-bit GF(2) Karatsuba stage. It splits both
// operands into halves and issues the lo, hi and mid sub-products one after
// another to a shared HxH carry-less sub-multiplier. The three results are
// collected and presented together to the overlap combiner.
//
// Build option: define KA_MID_CORRECT_EN to fold p_lo and p_hi into the
// middle term (true Karatsuba middle term). When it is left undefined, p_mid
// carries the raw (AL^AH)(BL^BH) product. Timing is the same in both builds.
module ka_split_sequencer_72bit #(
   parameter int N = 72
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [N-1:0]     a_in,
   input  logic [N-1:0]     b_in,
   output logic             sm_req_valid,
   input  logic             sm_req_ready,
   output logic [N/2-1:0]   sm_a,
   output logic [N/2-1:0]   sm_b,
   input  logic             sm_rsp_valid,
   input  logic [N-2:0]     sm_rsp,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [N-2:0]     p_lo,
   output logic [N-2:0]     p_mid,
   output logic [N-2:0]     p_hi
);

   localparam int H  = N / 2;
   localparam int PW = 2 * H - 1;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_ISSUE_LO  = 3'd1,
      ST_WAIT_LO   = 3'd2,
      ST_ISSUE_HI  = 3'd3,
      ST_WAIT_HI   = 3'd4,
      ST_ISSUE_MID = 3'd5,
      ST_WAIT_MID  = 3'd6,
      ST_DONE      = 3'd7
   } state_t;

   state_t        state_q, state_d;
   logic [N-1:0]  a_q, a_d;
   logic [N-1:0]  b_q, b_d;
   logic [PW-1:0] p_lo_q, p_lo_d;
   logic [PW-1:0] p_mid_q, p_mid_d;
   logic [PW-1:0] p_hi_q, p_hi_d;
   logic [PW-1:0] mid_capture;

   // Operand halves taken from the captured registers, not the live inputs.
   logic [H-1:0] al, ah, bl, bh;
   assign al = a_q[H-1:0];
   assign ah = a_q[N-1:H];
   assign bl = b_q[H-1:0];
   assign bh = b_q[N-1:H];

   // State and datapath registers; asynchronous reset returns everything to zero/IDLE.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         a_q     <= '0;
         b_q     <= '0;
         p_lo_q  <= '0;
         p_mid_q <= '0;
         p_hi_q  <= '0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         p_lo_q  <= p_lo_d;
         p_mid_q <= p_mid_d;
         p_hi_q  <= p_hi_d;
      end
   end

   // Next-state logic: each ISSUE waits for request acceptance, each WAIT for
   // the first response pulse seen after the request handshake.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:      if (in_valid)     state_d = ST_ISSUE_LO;
         ST_ISSUE_LO:  if (sm_req_ready) state_d = ST_WAIT_LO;
         ST_WAIT_LO:   if (sm_rsp_valid) state_d = ST_ISSUE_HI;
         ST_ISSUE_HI:  if (sm_req_ready) state_d = ST_WAIT_HI;
         ST_WAIT_HI:   if (sm_rsp_valid) state_d = ST_ISSUE_MID;
         ST_ISSUE_MID: if (sm_req_ready) state_d = ST_WAIT_MID;
         ST_WAIT_MID:  if (sm_rsp_valid) state_d = ST_DONE;
         ST_DONE:      if (out_ready)    state_d = ST_IDLE;
         default:                        state_d = ST_IDLE;
      endcase
   end

`ifdef KA_MID_CORRECT_EN
   // Fold the outer products in so the combiner can overlap p_mid directly.
   assign mid_capture = sm_rsp ^ p_lo_q ^ p_hi_q;
`else
   // Raw middle product; the downstream stage applies the correction.
   assign mid_capture = sm_rsp;
`endif

   // Datapath: capture operands on input handshake, capture each sub-product
   // into its slot only in the matching WAIT state (stray responses ignored).
   always_comb begin
      a_d     = a_q;
      b_d     = b_q;
      p_lo_d  = p_lo_q;
      p_mid_d = p_mid_q;
      p_hi_d  = p_hi_q;
      if (state_q == ST_IDLE && in_valid) begin
         a_d = a_in;
         b_d = b_in;
      end
      if (state_q == ST_WAIT_LO && sm_rsp_valid) begin
         p_lo_d = sm_rsp;
      end
      if (state_q == ST_WAIT_HI && sm_rsp_valid) begin
         p_hi_d = sm_rsp;
      end
      if (state_q == ST_WAIT_MID && sm_rsp_valid) begin
         p_mid_d = mid_capture;
      end
   end

   // Moore outputs decoded from state; operands are driven only while a
   // request is pending, so they stay stable through any request stall.
   always_comb begin
      in_ready     = 1'b0;
      sm_req_valid = 1'b0;
      sm_a         = '0;
      sm_b         = '0;
      out_valid    = 1'b0;
      case (state_q)
         ST_IDLE: in_ready = 1'b1;
         ST_ISSUE_LO: begin
            sm_req_valid = 1'b1;
            sm_a         = al;
            sm_b         = bl;
         end
         ST_ISSUE_HI: begin
            sm_req_valid = 1'b1;
            sm_a         = ah;
            sm_b         = bh;
         end
         ST_ISSUE_MID: begin
            sm_req_valid = 1'b1;
            sm_a         = al ^ ah;
            sm_b         = bl ^ bh;
         end
         ST_DONE: out_valid = 1'b1;
         default: ;
      endcase
   end

   assign p_lo  = p_lo_q;
   assign p_mid = p_mid_q;
   assign p_hi  = p_hi_q;

endmodule

// File: tb/tb_ka_split_sequencer_72bit.sv
// tb_ka_split_sequencer_72bit
// Directed and random bench for ka_split_sequencer_72bit with a behavioural
// carry-less sub-multiplier (configurable request stall and response delay).
// Honors KA_MID_CORRECT_EN to choose the expected form of p_mid.
module tb_ka_split_sequencer_72bit;

   localparam int N  = 72;
   localparam int H  = 36;
   localparam int PW = 71;

`ifdef KA_MID_CORRECT_EN
   localparam logic [PW-1:0] EXP_MID_UNIT = 71'd0;
`else
   localparam logic [PW-1:0] EXP_MID_UNIT = 71'd1;
`endif

   logic          clk;
   logic          rst;
   logic          in_valid;
   logic          in_ready;
   logic [N-1:0]  a_in;
   logic [N-1:0]  b_in;
   logic          sm_req_valid;
   logic          sm_req_ready;
   logic [H-1:0]  sm_a;
   logic [H-1:0]  sm_b;
   logic          sm_rsp_valid;
   logic [PW-1:0] sm_rsp;
   logic          out_valid;
   logic          out_ready;
   logic [PW-1:0] p_lo;
   logic [PW-1:0] p_mid;
   logic [PW-1:0] p_hi;

   ka_split_sequencer_72bit #(.N(N)) dut (
      .clk          (clk),
      .rst          (rst),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .a_in         (a_in),
      .b_in         (b_in),
      .sm_req_valid (sm_req_valid),
      .sm_req_ready (sm_req_ready),
      .sm_a         (sm_a),
      .sm_b         (sm_b),
      .sm_rsp_valid (sm_rsp_valid),
      .sm_rsp       (sm_rsp),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .p_lo         (p_lo),
      .p_mid        (p_mid),
      .p_hi         (p_hi)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check_val(input string tag, input logic [142:0] got, input logic [142:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic logic [PW-1:0] clmul36(input logic [H-1:0] x, input logic [H-1:0] y);
      logic [PW-1:0] r;
      r = '0;
      for (int i = 0; i < H; i++)
         if (y[i]) r ^= ({35'b0, x} << i);
      return r;
   endfunction

   function automatic logic [142:0] clmul72(input logic [N-1:0] x, input logic [N-1:0] y);
      logic [142:0] r;
      r = '0;
      for (int i = 0; i < N; i++)
         if (y[i]) r ^= ({71'b0, x} << i);
      return r;
   endfunction

   function automatic logic [142:0] combine(input logic [PW-1:0] lo, input logic [PW-1:0] mid,
                                            input logic [PW-1:0] hi);
      logic [PW-1:0] m;
      m = mid;
`ifndef KA_MID_CORRECT_EN
      m = mid ^ lo ^ hi;
`endif
      return {72'b0, lo} ^ ({72'b0, m} << 36) ^ ({72'b0, hi} << 72);
   endfunction

   // Sub-multiplier model state
   bit            model_en  = 1'b1;
   int            stall_cfg = 0;
   int            delay_cfg = 1;
   int            stall_cnt = 0;
   bit            pending   = 1'b0;
   int            rsp_cnt   = 0;
   logic [PW-1:0] rsp_data  = '0;
   bit            last_valid = 1'b0;
   bit            last_ready = 1'b0;
   logic [H-1:0]  last_a = '0;
   logic [H-1:0]  last_b = '0;
   int            hs_count = 0;
   logic [H-1:0]  req_a [3];
   logic [H-1:0]  req_b [3];

   // Sub-multiplier model, driven on the falling edge
   initial begin
      forever begin
         @(negedge clk);
         if (rst) begin
            pending      = 1'b0;
            stall_cnt    = 0;
            last_valid   = 1'b0;
            last_ready   = 1'b0;
            sm_req_ready = 1'b0;
            if (model_en) sm_rsp_valid = 1'b0;
         end else if (model_en) begin
            sm_rsp_valid = 1'b0;
            if (last_valid && last_ready) begin
               pending  = 1'b1;
               rsp_cnt  = delay_cfg - 1;
               rsp_data = clmul36(last_a, last_b);
               if (hs_count < 3) begin
                  req_a[hs_count] = last_a;
                  req_b[hs_count] = last_b;
               end
               hs_count++;
            end
            if (pending) begin
               if (rsp_cnt == 0) begin
                  sm_rsp_valid = 1'b1;
                  sm_rsp       = rsp_data;
                  pending      = 1'b0;
               end else begin
                  rsp_cnt--;
               end
            end
            if (last_valid && !last_ready && sm_req_valid) begin
               check_val("stall_sm_a", sm_a, last_a);
               check_val("stall_sm_b", sm_b, last_b);
            end
            if (sm_req_valid) begin
               if (stall_cnt < stall_cfg) begin
                  sm_req_ready = 1'b0;
                  stall_cnt++;
               end else begin
                  sm_req_ready = 1'b1;
               end
            end else begin
               sm_req_ready = 1'b0;
               stall_cnt    = 0;
            end
            last_valid = sm_req_valid;
            last_ready = sm_req_ready;
            last_a     = sm_a;
            last_b     = sm_b;
         end
      end
   end

   // Present one operand pair and wait (bounded) for out_valid; returns latency.
   task automatic run_op(input logic [N-1:0] a, input logic [N-1:0] b, output int lat);
      int cyc;
      @(negedge clk);
      check_val("in_ready_idle", in_ready, 1'b1);
      hs_count = 0;
      in_valid = 1'b1;
      a_in     = a;
      b_in     = b;
      @(posedge clk);
      #1 in_valid = 1'b0;
      cyc = 0;
      while (cyc < 200) begin
         @(posedge clk);
         cyc++;
         #1;
         if (out_valid) break;
      end
      if (!out_valid) check_val("out_valid_timeout", out_valid, 1'b1);
      lat = cyc;
   endtask

   // Complete the output handshake; block must be back in IDLE next cycle.
   task automatic finish_op();
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      in_valid  = 1'b0;
      check_val("out_valid_drop", out_valid, 1'b0);
      check_val("in_ready_after", in_ready, 1'b1);
   endtask

   initial begin
      int            lat;
      logic [95:0]   r;
      logic [N-1:0]  ra, rb;

      rst = 1'b1; in_valid = 1'b0; a_in = '0; b_in = '0; out_ready = 1'b0;
      sm_req_ready = 1'b0; sm_rsp_valid = 1'b0; sm_rsp = '0;

      // Reset values
      #2;
      check_val("rst_in_ready", in_ready, 1'b1);
      check_val("rst_req_valid", sm_req_valid, 1'b0);
      check_val("rst_out_valid", out_valid, 1'b0);
      check_val("rst_p_lo", p_lo, '0);
      @(negedge clk);
      rst = 1'b0;

      // Minimal product: a=b=1
      run_op(72'd1, 72'd1, lat);
      $display("op a=1 b=1 lat=%0d p_lo=%h p_mid=%h p_hi=%h", lat, p_lo, p_mid, p_hi);
      check_val("min_latency", lat, 6);
      check_val("min_req0_a", req_a[0], 36'd1);
      check_val("min_req0_b", req_b[0], 36'd1);
      check_val("min_req1_a", req_a[1], 36'd0);
      check_val("min_req1_b", req_b[1], 36'd0);
      check_val("min_req2_a", req_a[2], 36'd1);
      check_val("min_req2_b", req_b[2], 36'd1);
      check_val("min_p_lo", p_lo, 71'd1);
      check_val("min_p_hi", p_hi, 71'd0);
      check_val("min_p_mid", p_mid, EXP_MID_UNIT);
      finish_op();

      // Middle term: a=x^36, b=1
      run_op(72'd1 << 36, 72'd1, lat);
      $display("op a=x^36 b=1 lat=%0d p_lo=%h p_mid=%h p_hi=%h", lat, p_lo, p_mid, p_hi);
      check_val("mid_p_lo", p_lo, 71'd0);
      check_val("mid_p_hi", p_hi, 71'd0);
      check_val("mid_p_mid", p_mid, 71'd1);
      finish_op();

      // Request stalls and delayed responses
      stall_cfg = 3; delay_cfg = 4;
      run_op(72'd1, 72'd1, lat);
      $display("op stalled a=1 b=1 lat=%0d", lat);
      check_val("stall_latency", lat, 24);
      check_val("stall_p_lo", p_lo, 71'd1);
      check_val("stall_p_hi", p_hi, 71'd0);
      check_val("stall_p_mid", p_mid, EXP_MID_UNIT);
      finish_op();
      stall_cfg = 0; delay_cfg = 1;

      // Output backpressure, with a competing input offered the whole time
      run_op(72'd1, 72'd1, lat);
      in_valid = 1'b1; a_in = 72'hFF; b_in = 72'hFF;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check_val("bp_out_valid", out_valid, 1'b1);
         check_val("bp_in_ready", in_ready, 1'b0);
         check_val("bp_p_lo", p_lo, 71'd1);
         check_val("bp_p_mid", p_mid, EXP_MID_UNIT);
         check_val("bp_p_hi", p_hi, 71'd0);
      end
      $display("op backpressure held 5 cycles");
      finish_op();

      // Reset in the middle of WAIT_HI, then a late stray response
      delay_cfg = 4;
      @(negedge clk);
      hs_count = 0;
      in_valid = 1'b1; a_in = 72'h5; b_in = 72'h3;
      @(posedge clk);
      #1 in_valid = 1'b0;
      for (int i = 0; i < 100 && hs_count < 2; i++) @(negedge clk);
      check_val("pre_rst_p_lo", p_lo, 71'hF);
      #2 rst = 1'b1;
      #1;
      check_val("arst_in_ready", in_ready, 1'b1);
      check_val("arst_req_valid", sm_req_valid, 1'b0);
      check_val("arst_sm_a", sm_a, '0);
      check_val("arst_sm_b", sm_b, '0);
      check_val("arst_out_valid", out_valid, 1'b0);
      check_val("arst_p_lo", p_lo, '0);
      check_val("arst_p_mid", p_mid, '0);
      check_val("arst_p_hi", p_hi, '0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      model_en = 1'b0;
      #1 check_val("post_rst_in_ready", in_ready, 1'b1);
      @(negedge clk);
      sm_rsp_valid = 1'b1; sm_rsp = 71'h1234;
      @(negedge clk);
      sm_rsp_valid = 1'b0;
      repeat (3) @(negedge clk);
      check_val("stray_out_valid", out_valid, 1'b0);
      check_val("stray_in_ready", in_ready, 1'b1);
      check_val("stray_p_lo", p_lo, '0);
      check_val("stray_p_hi", p_hi, '0);
      $display("op reset mid-WAIT_HI and stray response");
      model_en = 1'b1; delay_cfg = 1;

      // All-ones operands
      run_op({N{1'b1}}, {N{1'b1}}, lat);
      check_val("ones_product", combine(p_lo, p_mid, p_hi), clmul72({N{1'b1}}, {N{1'b1}}));
      $display("op a=all-ones b=all-ones lat=%0d", lat);
      finish_op();

      // Random regression
      for (int k = 0; k < 1000; k++) begin
         r  = {$urandom(), $urandom(), $urandom()};
         ra = r[71:0];
         r  = {$urandom(), $urandom(), $urandom()};
         rb = r[71:0];
         run_op(ra, rb, lat);
         check_val("rand_product", combine(p_lo, p_mid, p_hi), clmul72(ra, rb));
         $display("op rand %0d a=%h b=%h lat=%0d", k, ra, rb, lat);
         finish_op();
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
